// File: rtl/alu_md.sv
// rtl/alu_md.sv - single-cycle ALU with iterative radix-2 multiply/divide unit and HI/LO registers
module alu_md #(
  parameter int DATA_ALU = 32,
  parameter int OP_SZ    = 4,
  parameter int SH_SZ    = 5
) (
  input  logic                I_CLK,
  input  logic                I_RST_N,
  input  logic [DATA_ALU-1:0] I_A,
  input  logic [DATA_ALU-1:0] I_B,
  input  logic [OP_SZ-1:0]    I_OP,
  input  logic [SH_SZ-1:0]    I_SH,
  input  logic                I_START,
  output logic [DATA_ALU-1:0] O_RSL,
  output logic [DATA_ALU-1:0] O_HI,
  output logic [DATA_ALU-1:0] O_LO,
  output logic                O_BUSY,
  output logic                O_DONE,
  output logic                O_DIV0
);
  localparam int N  = DATA_ALU;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          state_q;
  logic [N-1:0]    hi_q, lo_q, a_q, b_q, acc_hi_q, acc_lo_q;
  logic [CW-1:0]   cnt_q;
  logic            div_q, sa_q, sb_q, zero_q, busy_q, done_q, div0_q;

  logic            is_md, accept, a_neg, b_neg, b_zero;
  logic [N-1:0]    mag_a, mag_b;
  logic [N:0]      mul_sum, div_sh;
  logic [N-1:0]    div_diff, hi_step, lo_step;
  logic            div_ge;
  logic [2*N-1:0]  prod, prod_fix;
  logic [N-1:0]    quo_fix, rem_fix;

  always_comb begin
    O_RSL = I_A + I_B;
    case (I_OP)
      OP_SZ'(2):            O_RSL = I_A << I_SH;
      OP_SZ'(3):            O_RSL = I_A >> I_SH;
      OP_SZ'(4):            O_RSL = {{(N-1){1'b0}}, (I_A < I_B)};
      OP_SZ'(5), OP_SZ'(6): O_RSL = I_A - I_B;
      OP_SZ'(7):            O_RSL = $signed(I_A) >>> I_SH;
      OP_SZ'(12):           O_RSL = hi_q;
      OP_SZ'(13):           O_RSL = lo_q;
      default:              O_RSL = I_A + I_B;
    endcase
  end

  // Opcodes 8-11: bit1 selects divide, bit0 selects unsigned.
  assign is_md  = (I_OP >= OP_SZ'(8)) && (I_OP <= OP_SZ'(11));
  assign accept = I_START && !busy_q && is_md;
  assign a_neg  = !I_OP[0] && I_A[N-1];
  assign b_neg  = !I_OP[0] && I_B[N-1];
  assign mag_a  = a_neg ? -I_A : I_A;
  assign mag_b  = b_neg ? -I_B : I_B;
  assign b_zero = (I_B == '0);

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_hi_q, acc_lo_q[N-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh[N-1:0] - b_q;
    if (div_q) begin
      hi_step = div_ge ? div_diff : div_sh[N-1:0];
      lo_step = {acc_lo_q[N-2:0], div_ge};
    end else begin
      hi_step = mul_sum[N:1];
      lo_step = {mul_sum[0], acc_lo_q[N-1:1]};
    end
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quo_fix  = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
    rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            busy_q   <= 1'b1;
            div_q    <= I_OP[1];
            a_q      <= I_A;
            b_q      <= mag_b;
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            acc_hi_q <= '0;
            acc_lo_q <= mag_a;
            cnt_q    <= '0;
            zero_q   <= I_OP[1] && b_zero;
            if (I_OP[1] && b_zero) begin
              state_q <= S_FIX;
            end else begin
              state_q <= S_CALC;
              div0_q  <= 1'b0;
            end
          end
        end
        S_CALC: begin
          acc_hi_q <= hi_step;
          acc_lo_q <= lo_step;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (zero_q) begin
            hi_q   <= a_q;
            lo_q   <= '1;
            div0_q <= 1'b1;
          end else if (div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_HI   = hi_q;
  assign O_LO   = lo_q;
  assign O_BUSY = busy_q;
  assign O_DONE = done_q;
  assign O_DIV0 = div0_q;
endmodule
